mag_power_ctrl: RTL and testbench

MAG_POWER_CTRL -- requirements
Module: mag_power_ctrl

---
 rtl/mag_power_ctrl.sv | 135 +++++++++++++
 tb/tb_mag_power_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_power_ctrl.sv
// Microwave magnetron power controller: cook-cycle state machine plus a
// duty-cycle modulator that drives the magnetron for lvl_q of every PERIOD clocks.
module mag_power_ctrl #(
  parameter int PWR_W     = 4,
  parameter int PERIOD    = 10,
  parameter int DONE_HOLD = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] power_level,
  output logic             mag_on,
  output logic [1:0]       state,
  output logic             timer_en,
  output logic             done_beep
);

  localparam int LVL_W = PWR_W + 1;
  localparam int PH_W  = PWR_W;
  localparam int BC_W  = $clog2(DONE_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_start_q;
  logic              r_start_seen;
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [LVL_W-1:0]  r_lvl;
  logic [LVL_W-1:0]  w_lvl_nxt;
  logic [BC_W-1:0]   r_beep_cnt;
  logic              r_mag;
  logic              r_ten;
  logic              r_beep;
  logic              w_press;

  function automatic logic [LVL_W-1:0] clamp_lvl(input logic [PWR_W-1:0] p);
    if ({1'b0, p} > LVL_W'(PERIOD)) return LVL_W'(PERIOD);
    return {1'b0, p};
  endfunction

  // The reset value of the edge register is not a real sample of startn, so a
  // button held through reset release must not be mistaken for a new press.
  assign w_press = r_start_seen & r_start_q & ~startn;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (clearn && w_press && door_closed && !timer_done) w_nxt = S_COOK;
      end
      S_COOK: begin
        if (!clearn)           w_nxt = S_IDLE;
        else if (!door_closed) w_nxt = S_PAUSE;
        else if (!stopn)       w_nxt = S_PAUSE;
        else if (timer_done)   w_nxt = S_DONE;
      end
      S_PAUSE: begin
        if (!clearn || !stopn)           w_nxt = S_IDLE;
        else if (w_press && door_closed) w_nxt = S_COOK;
      end
      S_DONE: begin
        if (!clearn || w_press || !door_closed) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_phase_nxt = '0;
    if (w_nxt == S_COOK) begin
      if (r_state == S_COOK)
        w_phase_nxt = (r_phase == PH_W'(PERIOD - 1)) ? '0 : r_phase + PH_W'(1);
      else
        w_phase_nxt = r_phase;
    end else if (w_nxt == S_PAUSE) begin
      w_phase_nxt = r_phase;
    end
  end

  // Power level is captured only on a fresh start; resuming from PAUSE keeps it.
  assign w_lvl_nxt = (r_state == S_IDLE && w_nxt == S_COOK) ? clamp_lvl(power_level) : r_lvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_start_q    <= 1'b1;
      r_start_seen <= 1'b0;
      r_phase      <= '0;
      r_lvl        <= '0;
      r_beep_cnt   <= '0;
      r_mag        <= 1'b0;
      r_ten        <= 1'b0;
      r_beep       <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_start_q    <= startn;
      r_start_seen <= 1'b1;
      r_phase      <= w_phase_nxt;
      r_lvl        <= w_lvl_nxt;
      r_mag        <= (w_nxt == S_COOK) && ({1'b0, w_phase_nxt} < w_lvl_nxt);
      r_ten        <= (w_nxt == S_COOK);
      if (w_nxt == S_DONE) begin
        if (r_state != S_DONE) begin
          r_beep_cnt <= BC_W'(1);
          r_beep     <= 1'b1;
        end else if (r_beep_cnt < BC_W'(DONE_HOLD)) begin
          r_beep_cnt <= r_beep_cnt + BC_W'(1);
          r_beep     <= 1'b1;
        end else begin
          r_beep     <= 1'b0;
        end
      end else begin
        r_beep_cnt <= '0;
        r_beep     <= 1'b0;
      end
    end
  end

  assign mag_on    = r_mag;
  assign state     = r_state;
  assign timer_en  = r_ten;
  assign done_beep = r_beep;

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Bench for mag_power_ctrl: table vectors, directed corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_mag_power_ctrl;

  localparam int PWR_W     = 4;
  localparam int PERIOD    = 10;
  localparam int DONE_HOLD = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             startn, stopn, clearn, door_closed, timer_done;
  logic [PWR_W-1:0] power_level;
  logic             mag_on, timer_en, done_beep;
  logic [1:0]       state;

  int nerr = 0;
  int nchk = 0;

  mag_power_ctrl #(.PWR_W(PWR_W), .PERIOD(PERIOD), .DONE_HOLD(DONE_HOLD)) dut (
    .clk(clk), .rstn(rstn), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
    .mag_on(mag_on), .state(state), .timer_en(timer_en), .done_beep(done_beep)
  );

  always #5 clk = ~clk;

  // Reference model: states 0 idle, 1 cook, 2 pause, 3 done; prev=-1 means
  // no startn sample taken since reset.
  typedef struct {
    int st; int phase; int lvl; int prev; int age;
    bit mag; bit beep; bit ten;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mstep(mdl_t c, bit sn, bit stp, bit clr, bit dr, bit td, int pl);
    mdl_t n = c;
    bit press = (c.prev == 1) && (sn == 1'b0);
    n.prev = sn;
    case (c.st)
      0: if (clr && press && dr && !td) n.st = 1;
      1: if (!clr) n.st = 0; else if (!dr || !stp) n.st = 2; else if (td) n.st = 3;
      2: if (!clr || !stp) n.st = 0; else if (press && dr) n.st = 1;
      default: if (!clr || press || !dr) n.st = 0;
    endcase
    if (n.st == 1) begin
      if (c.st == 1) n.phase = (c.phase + 1) % PERIOD;
    end else if (n.st != 2) begin
      n.phase = 0;
    end
    if (c.st == 0 && n.st == 1) n.lvl = (pl > PERIOD) ? PERIOD : pl;
    n.mag  = (n.st == 1) && (n.phase < n.lvl);
    n.ten  = (n.st == 1);
    n.age  = (n.st == 3) ? ((c.st == 3) ? c.age + 1 : 0) : 0;
    n.beep = (n.st == 3) && (n.age < DONE_HOLD);
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= '{0, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0};
    else       m <= mstep(m, startn, stopn, clearn, door_closed, timer_done, int'(power_level));
  end

  typedef struct {
    bit sn; bit stp; bit clr; bit dr; bit td; int pl;
    int st; bit mag; bit ten; bit beep;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    startn = 1; stopn = 1; clearn = 1; door_closed = 1; timer_done = 0;
  endtask

  initial begin
    //                sn stp clr dr td pl  st mag ten beep
    tbl[0]  = '{1, 1, 1, 1, 0,  3, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 1, 0,  3, 1, 1, 1, 0};
    tbl[2]  = '{0, 1, 1, 1, 0,  3, 1, 1, 1, 0};
    tbl[3]  = '{1, 1, 1, 1, 0,  3, 1, 1, 1, 0};
    tbl[4]  = '{1, 1, 1, 1, 0,  3, 1, 0, 1, 0};
    tbl[5]  = '{1, 1, 1, 0, 0,  3, 2, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 1, 0,  3, 2, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 0,  3, 1, 0, 1, 0};
    tbl[8]  = '{1, 1, 1, 1, 0,  3, 1, 0, 1, 0};
    tbl[9]  = '{1, 1, 1, 1, 1,  3, 3, 0, 0, 1};
    tbl[10] = '{1, 1, 1, 1, 1,  3, 3, 0, 0, 1};
    tbl[11] = '{0, 1, 1, 1, 1,  3, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 1, 1, 0, 15, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 1, 0, 15, 1, 1, 1, 0};
    tbl[14] = '{1, 0, 1, 1, 0, 15, 2, 0, 0, 0};
    tbl[15] = '{1, 0, 1, 1, 0, 15, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 1, 0, 15, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 1, 1, 0, 15, 0, 0, 0, 0};
    tbl[18] = '{1, 1, 1, 0, 0, 15, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 1, 0, 0, 15, 0, 0, 0, 0};
    tbl[20] = '{1, 1, 1, 1, 1, 15, 0, 0, 0, 0};
    tbl[21] = '{0, 1, 1, 1, 1, 15, 0, 0, 0, 0};

    rstn = 0;
    idle_inputs();
    power_level = 3;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_ten", timer_en, 0);
    chk("rst_beep", done_beep, 0);
    @(negedge clk);
    rstn = 1;

    for (int i = 0; i < 22; i++) begin
      startn = tbl[i].sn; stopn = tbl[i].stp; clearn = tbl[i].clr;
      door_closed = tbl[i].dr; timer_done = tbl[i].td; power_level = 4'(tbl[i].pl);
      step();
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_mag", i), mag_on, tbl[i].mag);
      chk($sformatf("vec%0d_ten", i), timer_en, tbl[i].ten);
      chk($sformatf("vec%0d_beep", i), done_beep, tbl[i].beep);
    end

    // Duty-cycle pattern at power 3.
    idle_inputs(); power_level = 3;
    step();
    for (int k = 0; k < 20; k++) begin
      startn = (k == 0) ? 1'b0 : 1'b1;
      step();
      chk($sformatf("duty3_k%0d", k), mag_on, ((k % PERIOD) < 3) ? 1 : 0);
      chk($sformatf("duty3_ten%0d", k), timer_en, 1);
    end

    // Door opens at phase 5, then resume from the same phase.
    for (int k = 0; k < 6; k++) step();
    door_closed = 0;
    step();
    chk("door_pause_state", state, 2);
    chk("door_pause_mag", mag_on, 0);
    chk("door_pause_ten", timer_en, 0);
    door_closed = 1;
    step();
    chk("pause_hold", state, 2);
    startn = 0;
    step();
    startn = 1;
    chk("resume_state", state, 1);
    chk("resume_mag_p5", mag_on, 0);
    for (int k = 0; k < 4; k++) step();
    chk("resume_mag_p9", mag_on, 0);
    step();
    chk("resume_mag_p0", mag_on, 1);

    // Timer expiry and beep duration.
    timer_done = 1;
    step();
    chk("done_state", state, 3);
    chk("done_mag", mag_on, 0);
    chk("done_beep_0", done_beep, 1);
    for (int k = 1; k < DONE_HOLD; k++) begin
      step();
      chk($sformatf("done_beep_%0d", k), done_beep, 1);
    end
    step();
    chk("beep_end", done_beep, 0);
    chk("done_stays", state, 3);
    step();
    chk("beep_end2", done_beep, 0);
    chk("done_stays2", state, 3);
    clearn = 0; timer_done = 0;
    step();
    chk("done_clear", state, 0);
    clearn = 1;

    // Clear, stop and timer all at once: clear wins.
    startn = 0;
    step();
    startn = 1;
    chk("prio_cook", state, 1);
    clearn = 0; stopn = 0; timer_done = 1;
    step();
    chk("prio_state", state, 0);
    chk("prio_beep", done_beep, 0);
    step();
    chk("prio_beep2", done_beep, 0);
    idle_inputs();

    // Power clamp and zero power.
    power_level = 15; startn = 0;
    step();
    startn = 1;
    chk("clamp_state", state, 1);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("clamp_mag%0d", k), mag_on, 1);
      step();
    end
    clearn = 0;
    step();
    clearn = 1; power_level = 0; startn = 0;
    step();
    startn = 1;
    chk("zero_state", state, 1);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("zero_mag%0d", k), mag_on, 0);
      step();
    end
    clearn = 0;
    step();
    clearn = 1;

    // Asynchronous reset mid-cook with startn held low through release.
    power_level = 15; startn = 0;
    step();
    chk("arst_cook", mag_on, 1);
    #2 rstn = 0;
    #1;
    chk("arst_mag", mag_on, 0);
    chk("arst_state", state, 0);
    chk("arst_ten", timer_en, 0);
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst_held%0d", k), state, 0);
    end
    startn = 1;
    step();
    startn = 0;
    step();
    startn = 1;
    chk("arst_new_press", state, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      startn      = ($urandom_range(0, 3) != 0) ? ~startn : startn;
      stopn       = ($urandom_range(0, 9) != 0);
      clearn      = ($urandom_range(0, 15) != 0);
      door_closed = ($urandom_range(0, 11) != 0);
      timer_done  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) power_level = 4'($urandom_range(0, 15));
      step();
      chk($sformatf("rnd%0d_state", k), state, m.st);
      chk($sformatf("rnd%0d_mag", k), mag_on, m.mag);
      chk($sformatf("rnd%0d_ten", k), timer_en, m.ten);
      chk($sformatf("rnd%0d_beep", k), done_beep, m.beep);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
